arm_mc_controller: RTL and testbench
====================================

ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings come from arm_ctrl_pkg.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 Instr  in  32  instruction register contents: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
REQ-005 ALUFlags  in  4  NZCV from the ALU for the current cycle.
REQ-006 PCWrite  out  1  PC register load strobe.
REQ-007 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 MemWrite  out  1  data memory write strobe.
REQ-009 IRWrite  out  1  instruction register load strobe.
REQ-010 RegWrite  out  1  register file write strobe.
REQ-011 ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC.
REQ-013 ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-014 ALUControl  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
REQ-015 ImmSrc  out  2  extender mode; equals Op (combinational).
REQ-016 RegSrc  out  2  RegSrc[0] = (Op==10), RegSrc[1] = (Op==01) (combinational).

Function
REQ-017 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, one state per cycle.
REQ-018 Transitions SHALL be:
- FETCH->DECODE.
- DECODE-> EXECI if Op=00 and Funct[5]=1; EXECR if Op=00 and Funct[5]=0; MEMADR if Op=01; BRANCH if Op=10; FETCH if Op=11 (no-op).
- MEMADR-> MEMRD if Funct[0]=1, else MEMWR.
- MEMRD->MEMWB; EXECR/EXECI->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
REQ-019 Latency SHALL be 5 cycles for LDR, 4 for STR, 4 for data-processing, 3 for B, and 2 for Op=11.
REQ-020 Per state (unlisted outputs 0, ALUControl=ADD):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp.
- ALUWB: ResultSrc=00, RegW.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Br.
REQ-021 With ALUOp, ALUControl SHALL decode Funct[4:1]: 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR, any other->ADD.
REQ-022 CondEx SHALL evaluate Cond against the stored NZCV for EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL (1110); Cond=1111 SHALL yield CondEx=0.
REQ-023 Output gating:
- RegWrite = RegW & CondEx.
- MemWrite = MemW & CondEx.
- PCWrite = FETCH | (CondEx & (Br | (RegW & Rd==15))).
REQ-024 NZCV SHALL load ALUFlags at the end of EXECR/EXECI only when Funct[0]=1 and CondEx=1; otherwise hold.
REQ-025 Instr SHALL be sampled combinationally each cycle; the block holds no copy of it.

Reset
REQ-026 While rst=1:
- state SHALL load FETCH and NZCV SHALL load 0000 at the next edge.
- PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0.
REQ-027 rst asserted mid-instruction SHALL abandon that instruction with no further write strobes; after release, the first cycle is FETCH.

Structure
REQ-028 arm_ctrl_pkg SHALL hold the state enum, the ALUControl, ResultSrc and ALUSrcB encodings, the Op codes and the Cond codes.
REQ-029 The NZCV register and CondEx evaluation SHALL form sub-module arm_cond_logic; the FSM and ALU decode stay in arm_mc_controller.

Verification
REQ-030 rst for 2 cycles, then Instr=E2821005 (ADD R1,R2,#5) -> states FETCH,DECODE,EXECI,ALUWB; ALUControl=00 in EXECI; RegWrite=1 only in ALUWB; NZCV unchanged.
REQ-031 Instr=E5903008 (LDR) -> 5 cycles; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. Instr=E5803008 (STR) -> MemWrite=1 for exactly 1 cycle in MEMWR.
REQ-032 Instr=E0500000 (SUBS) with ALUFlags=0100 in EXECR -> ALUControl=01; NZCV=0100 after EXECR.
REQ-033 With Z=1: Instr=0A000002 (BEQ) -> PCWrite=1 in BRANCH. Instr=1A000002 (BNE) -> PCWrite=0 in BRANCH; next state FETCH.
REQ-034 rst pulsed during MEMADR of an LDR -> no RegWrite/MemWrite; FETCH on the cycle after release; NZCV=0000. Instr with Cond=1111 (ALU op) -> RegWrite=0 throughout.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, mux selects,
// ALU operations, opcode classes and condition codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv is ordered {N, Z, C, V}; the reserved code 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bundle. The datapath (master) supplies Instr/ALUFlags;
// the controller (slave) returns control strobes plus its state and flags for debug.
interface arm_mc_controller_if;
  import arm_ctrl_pkg::*;

  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  state_t      state;
  logic [3:0]  nzcv;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, state, nzcv
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, state, nzcv
  );
endinterface

// File: rtl/arm_cond_logic.sv
// Stored NZCV flags and condition-code evaluation for the current instruction.
module arm_cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_w,
  output logic       cond_ex,
  output logic [3:0] nzcv
);

  assign cond_ex = cond_eval(cond, nzcv);

  // A flag-setting instruction whose condition fails leaves the flags untouched.
  always_ff @(posedge clk) begin
    if (rst) nzcv <= 4'b0000;
    else if (flag_w && cond_ex) nzcv <= alu_flags;
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU decode and condition-gated write strobes.
module arm_mc_controller
  import arm_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  arm_mc_controller_if.slave bus
);

  state_t      state_q, state_d;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd, cond;
  logic        regw, memw, br, alu_op, irw, adr_src, src_a;
  logic [1:0]  res_src, src_b, alu_ctl;
  logic        cond_ex;
  logic [3:0]  nzcv;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    regw    = 1'b0;
    memw    = 1'b0;
    br      = 1'b0;
    alu_op  = 1'b0;
    irw     = 1'b0;
    adr_src = 1'b0;
    src_a   = 1'b0;
    src_b   = SRCB_RD2;
    res_src = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        irw     = 1'b1;
        src_a   = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALURESULT;
        state_d = DECODE;
      end
      DECODE: begin
        src_a   = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALURESULT;
        case (op)
          OP_DP:   state_d = funct[5] ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        src_b   = SRCB_IMM;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        res_src = RES_DATA;
        regw    = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        memw    = 1'b1;
      end
      EXECR: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        src_b   = SRCB_IMM;
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      ALUWB:  regw = 1'b1;
      BRANCH: begin
        src_b   = SRCB_IMM;
        res_src = RES_ALURESULT;
        br      = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Unlisted Funct[4:1] patterns fall back to ADD.
  always_comb begin
    alu_ctl = ALU_ADD;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: alu_ctl = ALU_ADD;
        4'b0010: alu_ctl = ALU_SUB;
        4'b0000: alu_ctl = ALU_AND;
        4'b1100: alu_ctl = ALU_ORR;
        default: alu_ctl = ALU_ADD;
      endcase
    end
  end

  arm_cond_logic u_cond (
    .clk       (clk),
    .rst       (rst),
    .cond      (cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (alu_op & funct[0]),
    .cond_ex   (cond_ex),
    .nzcv      (nzcv)
  );

  // Write strobes are masked while reset is held so an abandoned instruction commits nothing.
  assign bus.PCWrite    = ~rst & ((state_q == FETCH) | (cond_ex & (br | (regw & (rd == 4'd15)))));
  assign bus.IRWrite    = ~rst & irw;
  assign bus.RegWrite   = ~rst & regw & cond_ex;
  assign bus.MemWrite   = ~rst & memw & cond_ex;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.state      = state_q;
  assign bus.nzcv       = nzcv;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: the driver queues the expected per-cycle
// control vector of each instruction, the monitor compares one vector per cycle.
module tb_arm_mc_controller;
  import arm_ctrl_pkg::*;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  arm_mc_controller_if bus();

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  arm_mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, pending=%0d required=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic push(input string nm, input state_t st, input logic pcw, input logic adr,
                      input logic memw, input logic irw, input logic regw, input logic [1:0] rsrc,
                      input logic asa, input logic [1:0] asb, input logic [1:0] aluc,
                      input logic [3:0] nz);
    logic [1:0] opc;
    logic [1:0] rs;
    opc = bus.Instr[27:26];
    rs  = {opc == 2'b01, opc == 2'b10};
    exp_q.push_back({st, pcw, adr, memw, irw, regw, rsrc, asa, asb, aluc, opc, rs, nz});
    name_q.push_back(nm);
  endtask

  task automatic p_fetch(input string nm, input logic [3:0] nz);
    push({nm, ".fetch"}, FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, nz);
  endtask

  task automatic p_decode(input string nm, input logic [3:0] nz);
    push({nm, ".decode"}, DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, nz);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_instr(input logic [31:0] ins, input logic [3:0] flags);
    bus.Instr    = ins;
    bus.ALUFlags = flags;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
               bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
               bus.RegSrc, bus.nzcv};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got state=%0d pcw=%b adr=%b memw=%b irw=%b regw=%b rsrc=%b asa=%b asb=%b aluc=%b imm=%b regsrc=%b nzcv=%b, required %h (got %h)",
                 nm, act_v[23:20], act_v[19], act_v[18], act_v[17], act_v[16], act_v[15],
                 act_v[14:13], act_v[12], act_v[11:10], act_v[9:8], act_v[7:6], act_v[5:4],
                 act_v[3:0], exp_v, act_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    set_instr(32'hE282_1005, 4'b1111);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push("reset", FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD R1,R2,#5 with flags on the bus but S=0: NZCV must stay 0000
    p_fetch("add", 4'b0000);
    p_decode("add", 4'b0000);
    push("add.execi", EXECI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000);
    push("add.aluwb", ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000);
    cycles(4);

    // ORR PC,PC,R2: ALUControl=ORR and PCWrite in ALUWB since Rd=15
    set_instr(32'hE18F_F002, 4'b0000);
    p_fetch("orr", 4'b0000);
    p_decode("orr", 4'b0000);
    push("orr.execr", EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 4'b0000);
    push("orr.aluwb", ALUWB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000);
    cycles(4);

    // LDR
    set_instr(32'hE590_3008, 4'b0000);
    p_fetch("ldr", 4'b0000);
    p_decode("ldr", 4'b0000);
    push("ldr.memadr", MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000);
    push("ldr.memrd", MEMRD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000);
    push("ldr.memwb", MEMWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 4'b0000);
    cycles(5);

    // STR
    set_instr(32'hE580_3008, 4'b0000);
    p_fetch("str", 4'b0000);
    p_decode("str", 4'b0000);
    push("str.memadr", MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000);
    push("str.memwr", MEMWR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000);
    cycles(4);

    // SUBS with Z from the ALU: flags load at the end of EXECR
    set_instr(32'hE050_0000, 4'b0100);
    p_fetch("subs", 4'b0000);
    p_decode("subs", 4'b0000);
    push("subs.execr", EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0000);
    push("subs.aluwb", ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100);
    cycles(4);

    // BEQ taken with Z=1
    set_instr(32'h0A00_0002, 4'b0000);
    p_fetch("beq", 4'b0100);
    p_decode("beq", 4'b0100);
    push("beq.branch", BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 4'b0100);
    cycles(3);

    // BNE not taken with Z=1
    set_instr(32'h1A00_0002, 4'b0000);
    p_fetch("bne", 4'b0100);
    p_decode("bne", 4'b0100);
    push("bne.branch", BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 4'b0100);
    cycles(3);

    // Op=11 no-op: two cycles then FETCH
    set_instr(32'hEC00_0000, 4'b0000);
    p_fetch("nop", 4'b0100);
    p_decode("nop", 4'b0100);
    cycles(2);

    // LDR abandoned by a reset pulse in MEMADR, then rerun from FETCH with NZCV cleared
    set_instr(32'hE590_3008, 4'b0000);
    p_fetch("ldr_rst", 4'b0100);
    p_decode("ldr_rst", 4'b0100);
    push("ldr_rst.memadr", MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0100);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    p_fetch("ldr_post", 4'b0000);
    p_decode("ldr_post", 4'b0000);
    push("ldr_post.memadr", MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000);
    push("ldr_post.memrd", MEMRD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000);
    push("ldr_post.memwb", MEMWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 4'b0000);
    cycles(5);

    // Cond=1111 ADD: never writes the register file
    set_instr(32'hF282_1005, 4'b0000);
    p_fetch("nv", 4'b0000);
    p_decode("nv", 4'b0000);
    push("nv.execi", EXECI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0000);
    push("nv.aluwb", ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000);
    cycles(4);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
